fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of the async FIFO among
//  NREQ requesters in the write clock domain. Grants one owner at a time for a
//  burst of up to BURST beats, drives wr_data/wr_inc and obeys wr_full backpressure.
//  Sits directly in front of the FIFO write side; all logic on the FIFO's wr_clk.
// PARAMETERS
//  DSIZE  8  data width, equals the FIFO DSIZE
//  NREQ   4  number of requesters, 2..8
//  BURST  4  max beats per grant before rotating, >=1
// PORTS
//  clk        in   1           write-domain clock, connected to the FIFO wr_clk
//  rst        in   1           asynchronous, active-high reset, connected to wr_rst
//  req_valid  in   NREQ        requester i has a beat on req_data[i]
//  req_data   in   NREQ*DSIZE  packed; slice i = [i*DSIZE +: DSIZE]
//  req_ready  out  NREQ        beat i accepted this cycle (valid&ready = transfer)
//  gnt        out  NREQ        one-hot current owner, registered; 0 = none
//  wr_data    out  DSIZE       to FIFO wr_data
//  wr_inc     out  1           to FIFO wr_inc
//  wr_full    in   1           from FIFO wr_full
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-high. On rst: state=IDLE, gnt=0,
//    last=NREQ-1 (so requester 0 wins first), beat_cnt=0, req_ready=0, wr_inc=0.
//  - States IDLE, GRANT. IDLE: gnt=0, no transfers. If any req_valid, pick winner
//    by round-robin search from last+1 upward, with wrap; load gnt, beat_cnt=0;
//    go to GRANT next edge. Grant latency is 1 cycle from req_valid to gnt.
//  - GRANT, owner o: xfer = req_valid[o] & ~wr_full. req_ready[o]=xfer and all other
//    ready bits are 0. wr_inc=xfer. wr_data=req_data slice o. Path from wr_full to
//    wr_inc is combinational, so no write is ever issued while wr_full=1.
//  - On xfer, beat_cnt increments. End of grant occurs when (xfer & beat_cnt==BURST-1)
//    or req_valid[o]==0. At end of grant: last=o; re-arbitrate the same cycle from
//    o+1, with o at lowest priority. If there is a winner, the next-cycle gnt = winner
//    with beat_cnt=0 (back-to-back handoff, no bubble). Otherwise go to IDLE.
//  - wr_full=1 with req_valid[o]=1: hold grant, no beat counted, wait indefinitely.
//  - A requester that drops valid mid-burst forfeits the rest of its burst.
//  - NREQ=1: the owner is re-granted each burst. BURST=1: rotate after every beat.
//  - beat_cnt width is $clog2(BURST)+1. last/owner index width is $clog2(NREQ).
//  - Async rst mid-burst: everything returns to reset values immediately; no
//    wr_inc is issued while rst=1.
// CONFIGURATION
//  FIFO_ARB_STALL_CNT_EN defined: adds output port stall_cnt [15:0]. It counts
//    cycles in GRANT with req_valid[o]&wr_full, saturates at 16'hFFFF, and is
//    cleared by rst only.
//  FIFO_ARB_STALL_CNT_EN undefined: the port and the counter do not exist.
//    All other behaviour is identical.
// TESTING
//  1 rst released, req_valid=4'b0001, wr_full=0, 6 beats A0..A5 -> gnt=0001 after
//    1 cycle; A0..A3 written, then 1 rotation (only req0 valid, re-granted), A4,A5.
//  2 req_valid=4'b1111 held, BURST=4 -> grant order 0,1,2,3,0; exactly 4 wr_inc per
//    grant, no idle cycle between owners.
//  3 owner 2 mid-burst, wr_full=1 for 5 cycles -> wr_inc=0, req_ready=0, gnt stays
//    0100, beat_cnt unchanged; burst resumes when wr_full=0.
//  4 req1 drops valid after 2 beats while req3 is valid -> next cycle gnt=1000,
//    last=1.
//  5 rst pulsed during a burst -> gnt=0, wr_inc=0 asynchronously; the first grant
//    after reset goes to requester 0.
//  6 FIFO_ARB_STALL_CNT_EN: 10 stalled cycles -> stall_cnt=10; forced near the max
//    value, the counter holds at 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the write port of the async FIFO among NREQ
// requesters in the write clock domain. An owner keeps the port for up to
// BURST beats. wr_full gates wr_inc combinationally, so no write is issued
// while the FIFO is full.
// Optional feature: define FIFO_ARB_STALL_CNT_EN to add the 16-bit stall_cnt
// output, a saturating count of GRANT cycles stalled by wr_full.

module fifo_wr_arbiter #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       gnt,
  output logic [DSIZE-1:0]      wr_data,
  output logic                  wr_inc,
  input  logic                  wr_full
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(BURST) + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last;
  logic [CW-1:0]   beat_cnt;

  logic            owner_valid;
  logic            xfer;
  logic            burst_done;
  logic            grant_end;
  logic [IW-1:0]   arb_base;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;

  // Transfer qualification for the current owner; wr_full blocks the beat.
  always_comb begin
    owner_valid = req_valid[owner];
    xfer        = (state == GRANT) && owner_valid && !wr_full;
    burst_done  = xfer && (beat_cnt == CW'(BURST - 1));
    grant_end   = (state == GRANT) && (burst_done || !owner_valid);
  end

  // Round-robin search starting just above the reference index, wrapping.
  // While granted the reference is the current owner, so an ending owner
  // drops to lowest priority and a handoff needs no idle cycle.
  always_comb begin
    int unsigned cand;
    arb_base  = (state == GRANT) ? owner : last;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(arb_base) + i) % NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
    win_onehot = NREQ'(1) << win_idx;
  end

  // Write-port drive: only the owner sees ready, and only on a real transfer.
  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[owner] = 1'b1;
    end
    wr_inc  = xfer;
    wr_data = req_data[owner*DSIZE +: DSIZE];
  end

  // Grant FSM: owner, one-hot grant, beat counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      last     <= IW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            owner    <= win_idx;
            gnt      <= win_onehot;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            last <= owner;
            if (win_found) begin
              owner    <= win_idx;
              gnt      <= win_onehot;
              beat_cnt <= '0;
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              beat_cnt <= '0;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where the owner has data but the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == GRANT) && owner_valid && wr_full && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DSIZE=8, NREQ=4, BURST=4).

module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  gnt;
  logic [7:0]  wr_data;
  logic        wr_inc;
  logic        wr_full;
  logic [7:0]  d [4];
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .wr_data   (wr_data),
    .wr_inc    (wr_inc),
    .wr_full   (wr_full)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always_comb begin
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = d[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    wr_full   = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int bubbles;
    int exp_o;

    // Test 1: single requester, 6 beats, re-granted after 4 with no bubble
    reset_dut();
    req_valid = 4'b0001;
    d[0]      = 8'hA0;
    @(negedge clk);
    check("t1_reset_gnt", 32'(gnt), 32'h0);
    check("t1_reset_inc", 32'(wr_inc), 32'h0);
    check("t1_reset_rdy", 32'(req_ready), 32'h0);
    tick();
    sent    = 0;
    bubbles = 0;
    for (int c = 0; c < 12 && sent < 6; c++) begin
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'h1);
      if (wr_inc) begin
        check("t1_data", 32'(wr_data), 32'hA0 + 32'(sent));
        check("t1_rdy", 32'(req_ready), 32'h1);
        sent++;
      end else begin
        bubbles++;
      end
      tick();
      d[0] = 8'hA0 + 8'(sent);
      if (sent == 6) req_valid = 4'b0000;
    end
    check("t1_sent", 32'(sent), 32'd6);
    check("t1_bubbles", 32'(bubbles), 32'd0);
    @(negedge clk);
    check("t1_end_inc", 32'(wr_inc), 32'h0);
    tick();
    @(negedge clk);
    check("t1_idle_gnt", 32'(gnt), 32'h0);

    // Test 2: all valid -> owners 0,1,2,3,0 with 4 beats each, back to back
    reset_dut();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'hC0 + 8'(i);
    @(negedge clk);
    check("t2_idle_gnt", 32'(gnt), 32'h0);
    tick();
    for (int k = 0; k < 20; k++) begin
      exp_o = (k / 4) % 4;
      @(negedge clk);
      check("t2_gnt", 32'(gnt), 32'h1 << exp_o);
      check("t2_inc", 32'(wr_inc), 32'h1);
      check("t2_data", 32'(wr_data), 32'hC0 + 32'(exp_o));
      tick();
    end

    // Test 3: owner 2 stalled by wr_full for 5 cycles, then finishes its burst
    reset_dut();
    req_valid = 4'b1100;
    d[2]      = 8'h20;
    d[3]      = 8'h30;
    @(negedge clk);
    tick();
    repeat (2) begin
      @(negedge clk);
      check("t3_pre_gnt", 32'(gnt), 32'h4);
      check("t3_pre_inc", 32'(wr_inc), 32'h1);
      tick();
    end
    wr_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3_stall_inc", 32'(wr_inc), 32'h0);
      check("t3_stall_rdy", 32'(req_ready), 32'h0);
      check("t3_stall_gnt", 32'(gnt), 32'h4);
      tick();
    end
    wr_full = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t3_post_gnt", 32'(gnt), 32'h4);
      check("t3_post_inc", 32'(wr_inc), 32'h1);
      check("t3_post_rdy", 32'(req_ready), 32'h4);
      check("t3_post_data", 32'(wr_data), 32'h20);
      tick();
    end
    @(negedge clk);
    check("t3_handoff_gnt", 32'(gnt), 32'h8);
    check("t3_handoff_data", 32'(wr_data), 32'h30);

    // Test 4: req1 drops valid after 2 beats, req3 takes over next cycle
    reset_dut();
    req_valid = 4'b1010;
    d[1]      = 8'h11;
    d[3]      = 8'h33;
    @(negedge clk);
    tick();
    repeat (2) begin
      @(negedge clk);
      check("t4_gnt", 32'(gnt), 32'h2);
      check("t4_data", 32'(wr_data), 32'h11);
      check("t4_inc", 32'(wr_inc), 32'h1);
      tick();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    check("t4_drop_inc", 32'(wr_inc), 32'h0);
    check("t4_drop_rdy", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("t4_new_gnt", 32'(gnt), 32'h8);
    check("t4_new_inc", 32'(wr_inc), 32'h1);
    check("t4_new_data", 32'(wr_data), 32'h33);
    check("t4_last", 32'(dut.last), 32'h1);

    // Test 5: asynchronous reset during a burst
    reset_dut();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'h50 + 8'(i);
    @(negedge clk);
    tick();
    repeat (2) begin
      @(negedge clk);
      check("t5_pre_inc", 32'(wr_inc), 32'h1);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_gnt", 32'(gnt), 32'h0);
    check("t5_async_inc", 32'(wr_inc), 32'h0);
    check("t5_async_rdy", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("t5_hold_inc", 32'(wr_inc), 32'h0);
    tick();
    check("t5_hold_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rel_gnt", 32'(gnt), 32'h0);
    tick();
    @(negedge clk);
    check("t5_first_gnt", 32'(gnt), 32'h1);
    check("t5_first_data", 32'(wr_data), 32'h50);

`ifdef FIFO_ARB_STALL_CNT_EN
    // Test 6: stall counter counts 10 stalled cycles and saturates
    reset_dut();
    check("t6_reset_cnt", 32'(stall_cnt), 32'h0);
    req_valid = 4'b0001;
    wr_full   = 1'b1;
    @(negedge clk);
    tick();
    repeat (10) begin
      @(negedge clk);
      tick();
    end
    check("t6_cnt10", 32'(stall_cnt), 32'd10);
    check("t6_gnt", 32'(gnt), 32'h1);
    force dut.stall_q = 16'hFFFD;
    release dut.stall_q;
    repeat (5) tick();
    check("t6_sat", 32'(stall_cnt), 32'hFFFF);
    wr_full = 1'b0;
    tick();
    check("t6_sat_hold", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
